// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: capture FSM states
// and the counter width both sides agree on.
package pwm_pkg;

  localparam int PWM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises an asynchronous input into the clk domain and produces
// single-cycle rise/fall strobes on the synchronised level.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      s_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal in clk cycles and
// flags inputs stuck high or low for a full counter range.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W           = PWM_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_o,
  output logic         meas_valid,
  output logic         stuck_high,
  output logic         stuck_low
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic s, rise, fall;

  cap_state_e   state, state_n;
  logic [W-1:0] per_cnt, per_n;
  logic [W-1:0] hi_cnt, hi_n;
  logic [W-1:0] period_n, high_n;
  logic         valid_n, stuck_high_n, stuck_low_n;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_o   <= '0;
      high_o     <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      state      <= state_n;
      per_cnt    <= per_n;
      hi_cnt     <= hi_n;
      period_o   <= period_n;
      high_o     <= high_n;
      meas_valid <= valid_n;
      stuck_high <= stuck_high_n;
      stuck_low  <= stuck_low_n;
    end
  end

  // In IDLE per_cnt doubles as the stuck-low timer; it only runs while
  // enabled and the line is low, so a line parked high is not called stuck low.
  always_comb begin
    state_n      = state;
    per_n        = per_cnt;
    hi_n         = hi_cnt;
    period_n     = period_o;
    high_n       = high_o;
    valid_n      = 1'b0;
    stuck_high_n = stuck_high;
    stuck_low_n  = stuck_low;

    unique case (state)
      IDLE: begin
        if (!en) begin
          per_n = '0;
        end else if (rise) begin
          state_n      = HIGH;
          per_n        = CNT_ONE;
          hi_n         = CNT_ONE;
          stuck_high_n = 1'b0;
          stuck_low_n  = 1'b0;
        end else if (s) begin
          per_n = '0;
        end else if (per_cnt == CNT_MAX) begin
          per_n        = '0;
          stuck_low_n  = 1'b1;
          stuck_high_n = 1'b0;
        end else begin
          per_n = per_cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!en) begin
          state_n = IDLE;
          per_n   = '0;
          hi_n    = '0;
        end else if (per_cnt == CNT_MAX) begin
          // A fall here would leave no room to count the low phase: abandon it.
          state_n = IDLE;
          per_n   = '0;
          hi_n    = '0;
          if (!fall) begin
            stuck_high_n = 1'b1;
            stuck_low_n  = 1'b0;
          end
        end else if (fall) begin
          state_n = LOW;
          per_n   = per_cnt + CNT_ONE;
        end else begin
          per_n = per_cnt + CNT_ONE;
          hi_n  = hi_cnt + CNT_ONE;
        end
      end

      LOW: begin
        if (!en) begin
          state_n = IDLE;
          per_n   = '0;
          hi_n    = '0;
        end else if (rise) begin
          state_n      = HIGH;
          period_n     = per_cnt;
          high_n       = hi_cnt;
          valid_n      = 1'b1;
          per_n        = CNT_ONE;
          hi_n         = CNT_ONE;
          stuck_high_n = 1'b0;
          stuck_low_n  = 1'b0;
        end else if (per_cnt == CNT_MAX) begin
          state_n      = IDLE;
          per_n        = '0;
          hi_n         = '0;
          stuck_low_n  = 1'b1;
          stuck_high_n = 1'b0;
        end else begin
          per_n = per_cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
        per_n   = '0;
        hi_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus random PWM
// traffic, checked every cycle against a timestamp-based reference model.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         meas_valid;
  logic         stuck_high;
  logic         stuck_low;

  int checks = 0;
  int errors = 0;

  pwm_capture #(.W(W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .period_o   (period_o),
    .high_o     (high_o),
    .meas_valid (meas_valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;

  // Reference model state: pin history stands in for the synchroniser delay,
  // measurements are differences between edge timestamps.
  logic pin_hist [0:SYNC];
  int   cyc, idle_since, rise_t, fall_t, elapsed;
  bit   armed, fell, s_now, s_prev, is_rise, is_fall;
  int   exp_period, exp_high;
  bit   exp_valid, exp_sh, exp_sl;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int period, input int high, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < period; i++) begin
        @(negedge clk);
        pwm_in = (i < high);
      end
    end
  endtask

  task automatic holdInput(input logic level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      pwm_in = level;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k <= SYNC; k++) pin_hist[k] = 1'b0;
        cyc = 0; idle_since = 0; rise_t = 0; fall_t = 0;
        armed = 0; fell = 0;
        exp_period = 0; exp_high = 0; exp_valid = 0; exp_sh = 0; exp_sl = 0;
      end else begin
        s_now   = pin_hist[SYNC-1];
        s_prev  = pin_hist[SYNC];
        is_rise = s_now & ~s_prev;
        is_fall = ~s_now & s_prev;
        exp_valid = 0;
        if (!armed) begin
          if (!en) idle_since = cyc + 1;
          else if (is_rise) begin
            armed = 1; rise_t = cyc; fell = 0; exp_sh = 0; exp_sl = 0;
          end else if (s_now) idle_since = cyc + 1;
          else if (cyc - idle_since == MAXC) begin
            exp_sl = 1; exp_sh = 0; idle_since = cyc + 1;
          end
        end else begin
          elapsed = cyc - rise_t;
          if (!en) begin
            armed = 0; idle_since = cyc + 1;
          end else if (!fell) begin
            if (elapsed == MAXC) begin
              armed = 0; idle_since = cyc + 1;
              if (!is_fall) begin exp_sh = 1; exp_sl = 0; end
            end else if (is_fall) begin
              fell = 1; fall_t = cyc;
            end
          end else if (is_rise) begin
            exp_period = elapsed; exp_high = fall_t - rise_t; exp_valid = 1;
            rise_t = cyc; fell = 0; exp_sh = 0; exp_sl = 0;
          end else if (elapsed == MAXC) begin
            armed = 0; exp_sl = 1; exp_sh = 0; idle_since = cyc + 1;
          end
        end
        for (int k = SYNC; k > 0; k--) pin_hist[k] = pin_hist[k-1];
        pin_hist[0] = pwm_in;
        cyc++;
      end
    end
  end

  // Cycle-by-cycle comparison, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checkOutput("period_o", period_o, exp_period);
      checkOutput("high_o", high_o, exp_high);
      checkOutput("meas_valid", meas_valid, exp_valid);
      checkOutput("stuck_high", stuck_high, exp_sh);
      checkOutput("stuck_low", stuck_low, exp_sl);
    end
  end

  initial begin
    int p, h, n;
    repeat (3) @(negedge clk);
    checkOutput("reset period_o", period_o, 0);
    checkOutput("reset meas_valid", meas_valid, 0);
    checkOutput("reset stuck_low", stuck_low, 0);
    rst = 1'b0;
    en  = 1'b1;

    $display("[TB] steady 100/25");
    applyStimulus(100, 25, 4);
    checkOutput("lit period 100", period_o, 100);
    checkOutput("lit high 25", high_o, 25);
    checkOutput("model period 100", exp_period, 100);

    $display("[TB] switch to 40/30");
    applyStimulus(40, 30, 4);
    checkOutput("lit period 40", period_o, 40);
    checkOutput("lit high 30", high_o, 30);

    $display("[TB] stuck low after enable");
    en = 1'b0;
    holdInput(1'b0, 5);
    en = 1'b1;
    holdInput(1'b0, 250);
    checkOutput("lit stuck_low early", stuck_low, 0);
    holdInput(1'b0, 10);
    checkOutput("lit stuck_low set", stuck_low, 1);
    checkOutput("model stuck_low set", exp_sl, 1);
    checkOutput("lit period held", period_o, 40);
    applyStimulus(20, 5, 3);
    checkOutput("lit stuck_low cleared", stuck_low, 0);
    checkOutput("lit period 20", period_o, 20);
    checkOutput("lit high 5", high_o, 5);

    $display("[TB] stuck high");
    holdInput(1'b1, 300);
    checkOutput("lit stuck_high set", stuck_high, 1);
    checkOutput("lit stuck_low clear", stuck_low, 0);
    checkOutput("lit high held", high_o, 5);
    holdInput(1'b0, 10);

    $display("[TB] glitch width and saturation edge");
    applyStimulus(10, 1, 4);
    checkOutput("lit period 10", period_o, 10);
    checkOutput("lit high 1", high_o, 1);
    checkOutput("lit stuck_high cleared", stuck_high, 0);
    applyStimulus(MAXC, 100, 3);
    checkOutput("lit period max", period_o, MAXC);
    checkOutput("lit high 100", high_o, 100);
    checkOutput("lit no flag at max", stuck_low, 0);

    $display("[TB] enable drop and reset mid-measurement");
    applyStimulus(100, 25, 2);
    holdInput(1'b1, 10);
    en = 1'b0;
    holdInput(1'b1, 15);
    holdInput(1'b0, 75);
    applyStimulus(100, 25, 2);
    checkOutput("lit period held disabled", period_o, 100);
    en = 1'b1;
    applyStimulus(100, 25, 2);
    holdInput(1'b1, 25);
    holdInput(1'b0, 30);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("lit rst period_o", period_o, 0);
    checkOutput("lit rst high_o", high_o, 0);
    @(negedge clk);
    rst = 1'b0;
    holdInput(1'b0, 45);
    applyStimulus(100, 25, 1);
    checkOutput("lit one rise no report", period_o, 0);
    applyStimulus(100, 25, 2);
    checkOutput("lit period after rst", period_o, 100);

    $display("[TB] random traffic");
    for (int seg = 0; seg < 40; seg++) begin
      p = $urandom_range(70, 2);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(3, 1);
      if ($urandom_range(5, 0) == 0) en = ~en;
      if ($urandom_range(9, 0) == 0) holdInput(1'(($urandom_range(1, 0))), $urandom_range(300, 200));
      applyStimulus(p, h, n);
    end
    en = 1'b1;
    applyStimulus(33, 7, 3);
    checkOutput("lit random tail period", period_o, 33);
    checkOutput("lit random tail high", high_o, 7);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
